z80_opcode_sequencer: RTL and testbench
=======================================

// Module: z80_opcode_sequencer
// PURPOSE
//  Consumes opcode bytes from OCF_fsm and operand bytes from the operand-read FSM (ODL/ODH).
//  Tracks CB/ED/DD/FD prefixes, fetches displacement and immediate bytes, and presents one
//  complete instruction per valid/ready handshake to the execute sequencer in control_fsm.
//  Drives ocf_start/od_start, so it decides which machine cycles run during instruction fetch.
// PARAMETERS
//  none (Z80 instruction set fixed)
// PORTS
//  clk          in   1   system clock
//  rst_L        in   1   reset, asynchronous assert, active low
//  ocf_start    out  1   1-cycle pulse: run an opcode-fetch (M1) cycle
//  ocf_done     in   1   1-cycle pulse: OCF complete, ocf_data valid this cycle
//  ocf_data     in   8   fetched opcode byte
//  od_start     out  1   1-cycle pulse: run an operand-data read (PC-addressed, non-M1)
//  od_done      in   1   1-cycle pulse: operand read complete, od_data valid this cycle
//  od_data      in   8   fetched operand byte
//  flush        in   1   discard the partial instruction, restart the fetch (jump/interrupt)
//  instr_valid  out  1   decoded instruction held stable on instr_* outputs
//  instr_ready  in   1   execute side accepts the instruction this cycle
//  instr_group  out  3   0 none,1 CB,2 ED,3 DD,4 FD,5 DDCB,6 FDCB
//  instr_opcode out  8   final opcode byte
//  instr_disp   out  8   index displacement d (0 if none)
//  instr_imm    out  16  immediate: n in [7:0] with [15:8]=0, or nn little-endian, or e
// BEHAVIOUR
//  Reset: all outputs 0, state FETCH, prefix cleared. First ocf_start comes 1 cycle after rst_L rises.
//  States: FETCH, WAIT_OCF, RD_DISP, RD_LO, RD_HI, XCB_DISP, XCB_OP, PRESENT.
//  FETCH: pulse ocf_start, go to WAIT_OCF. RD_* and XCB_* pulse od_start on entry, then wait for od_done.
//  WAIT_OCF on ocf_done, byte b:
//   - b=CB, no index prefix: group=CB, go to FETCH.
//   - b=ED: group=ED (drops any DD/FD), go to FETCH.
//   - b=DD/FD: group=DD/FD (last index prefix wins), go to FETCH.
//   - b=CB with DD/FD: group=DDCB/FDCB, go to XCB_DISP. Reads d, then XCB_OP reads the opcode
//     through od (non-M1). Then PRESENT.
//   - otherwise latch opcode; classify by x=b[7:6] y=b[5:3] z=b[2:0].
//  Classification:
//   - Group none/DD/FD, nn: (x0,z1,y even) | (x0,z2,y>=4) | (x3,z2) | (x3,z4) | C3 | CD.
//   - Group none/DD/FD, n: (x0,z6) | (x3,z6) | D3 | DB.
//   - Group none/DD/FD, e: (x0,z0,y>=2), placed in imm[7:0].
//   - ED: nn iff (x1,z3); otherwise none.
//   - CB: never has an operand.
//   - DD/FD needs disp iff opcode is 34|35|36 | (x1,(y6|z6),not 76) | (x2,z6).
//   - Read order: disp, then lo, then hi. DD 36 d n reads d then n.
//   - No operands: go straight to PRESENT.
//  PRESENT: instr_valid=1, instr_* stable until instr_valid&instr_ready.
//   - On accept: clear prefix/disp/imm, go to FETCH. Next ocf_start is the cycle after accept.
//  Latency: ocf_done of the final opcode to instr_valid is 1 cycle when no operands are read.
//   Otherwise it is 1 cycle after the last od_done.
//  flush:
//   - In FETCH/PRESENT: drop everything, go to FETCH. flush beats instr_ready in the same cycle.
//   - While a done is pending: mark abort, discard the completing byte, then go to FETCH.
//   - Never issue a new start while a cycle is outstanding.
//  Exactly one of ocf_start/od_start pulses per machine cycle. A done arriving with no
//   request outstanding is ignored.
//  rst_L low mid-instruction: immediate return to the reset state; outstanding done pulses are ignored.
// TESTING
//  3E 42 -> one ocf_start, one od_start; group0 opcode 3E imm 0042 valid 1 cycle after od_done.
//  C3 34 12 -> two od reads; imm 1234. Hold instr_ready=0 5 cycles: outputs stable, no start pulses.
//  DD 36 05 99 -> two ocf_starts, then d=05, then n. Result: group3 opcode 36 disp 05 imm 0099.
//  FD CB FE 46 -> two ocf_starts then two od_starts; group6 opcode 46 disp FE imm 0000.
//  DD FD ED 4B 00 80 -> group ED, opcode 4B, imm 8000, four ocf_starts.
//  Both cases return to FETCH, the first with no instr_valid:
//   - flush during RD_LO of 01 xx xx: the od_done byte is discarded, then ocf_start.
//   - rst_L low mid-instruction: outputs go to 0 immediately.

Source files
------------

// File: rtl/z80_opcode_sequencer.sv
// Z80 fetch sequencer: gathers prefixes, opcode, displacement and immediates into one instruction.
// instr_valid rises 1 cycle after the final done; instr_* hold, with no new fetch, until accepted.
module z80_opcode_sequencer (
    input  logic        clk,
    input  logic        rst_L,
    output logic        ocf_start,
    input  logic        ocf_done,
    input  logic [7:0]  ocf_data,
    output logic        od_start,
    input  logic        od_done,
    input  logic [7:0]  od_data,
    input  logic        flush,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [2:0]  instr_group,
    output logic [7:0]  instr_opcode,
    output logic [7:0]  instr_disp,
    output logic [15:0] instr_imm
);
    typedef enum logic [2:0] {
        FETCH, WAIT_OCF, RD_DISP, RD_LO, RD_HI, XCB_DISP, XCB_OP, PRESENT
    } state_t;

    localparam logic [2:0] G_NONE = 3'd0, G_CB = 3'd1, G_ED = 3'd2, G_DD = 3'd3,
                           G_FD = 3'd4, G_DDCB = 3'd5, G_FDCB = 3'd6;

    state_t      state, state_n;
    logic        run_q, out_q, abort_q, need_lo_q, need_hi_q;
    logic [2:0]  group_q;
    logic [7:0]  opcode_q, disp_q;
    logic [15:0] imm_q;

    logic        od_state, ocf_take, od_take, drop, clr;
    logic        is_idx, in_pfx, pfx_byte;
    logic [1:0]  x;
    logic [2:0]  y, z;
    logic        cls_nn, cls_n, cls_disp;

    assign x = ocf_data[7:6];
    assign y = ocf_data[5:3];
    assign z = ocf_data[2:0];

    assign od_state = (state == RD_DISP) || (state == RD_LO) || (state == RD_HI) ||
                      (state == XCB_DISP) || (state == XCB_OP);
    assign ocf_take = (state == WAIT_OCF) && out_q && ocf_done;
    assign od_take  = od_state && out_q && od_done;
    assign drop     = flush || abort_q;

    // After a CB or ED prefix the next byte is always the opcode, even if it looks like a prefix.
    assign is_idx   = (group_q == G_DD) || (group_q == G_FD);
    assign in_pfx   = (group_q == G_NONE) || is_idx;
    assign pfx_byte = in_pfx && ((ocf_data == 8'hCB) || (ocf_data == 8'hED) ||
                                 (ocf_data == 8'hDD) || (ocf_data == 8'hFD));

    always_comb begin
        cls_nn   = 1'b0;
        cls_n    = 1'b0;
        cls_disp = 1'b0;
        if (group_q == G_ED) begin
            cls_nn = (x == 2'd1) && (z == 3'd3);
        end else if (in_pfx) begin
            cls_nn = ((x == 2'd0) && (z == 3'd1) && !y[0]) ||
                     ((x == 2'd0) && (z == 3'd2) && (y >= 3'd4)) ||
                     ((x == 2'd3) && ((z == 3'd2) || (z == 3'd4))) ||
                     (ocf_data == 8'hC3) || (ocf_data == 8'hCD);
            cls_n  = (((x == 2'd0) || (x == 2'd3)) && (z == 3'd6)) ||
                     (ocf_data == 8'hD3) || (ocf_data == 8'hDB) ||
                     ((x == 2'd0) && (z == 3'd0) && (y >= 3'd2));
            cls_disp = is_idx &&
                       ((ocf_data == 8'h34) || (ocf_data == 8'h35) || (ocf_data == 8'h36) ||
                        ((x == 2'd1) && ((y == 3'd6) || (z == 3'd6)) && (ocf_data != 8'h76)) ||
                        ((x == 2'd2) && (z == 3'd6)));
        end
    end

    always_comb begin
        state_n   = state;
        ocf_start = 1'b0;
        od_start  = 1'b0;
        clr       = 1'b0;
        case (state)
            FETCH: begin
                if (flush) begin
                    clr = 1'b1;
                end else if (run_q) begin
                    ocf_start = 1'b1;
                    state_n   = WAIT_OCF;
                end
            end
            WAIT_OCF: begin
                if (ocf_take) begin
                    if (drop) begin
                        clr     = 1'b1;
                        state_n = FETCH;
                    end else if (pfx_byte) begin
                        state_n = ((ocf_data == 8'hCB) && is_idx) ? XCB_DISP : FETCH;
                    end else if (cls_disp) begin
                        state_n = RD_DISP;
                    end else if (cls_nn || cls_n) begin
                        state_n = RD_LO;
                    end else begin
                        state_n = PRESENT;
                    end
                end
            end
            RD_DISP, RD_LO, RD_HI, XCB_DISP, XCB_OP: begin
                // First cycle in the state issues the read; later cycles wait for its done.
                if (!out_q) begin
                    if (flush) begin
                        clr     = 1'b1;
                        state_n = FETCH;
                    end else begin
                        od_start = 1'b1;
                    end
                end else if (od_take) begin
                    if (drop) begin
                        clr     = 1'b1;
                        state_n = FETCH;
                    end else begin
                        case (state)
                            RD_DISP:  state_n = need_lo_q ? RD_LO : PRESENT;
                            RD_LO:    state_n = need_hi_q ? RD_HI : PRESENT;
                            XCB_DISP: state_n = XCB_OP;
                            default:  state_n = PRESENT;
                        endcase
                    end
                end
            end
            PRESENT: begin
                if (flush || instr_ready) begin
                    clr     = 1'b1;
                    state_n = FETCH;
                end
            end
            default: state_n = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) state <= FETCH;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            run_q     <= 1'b0;
            out_q     <= 1'b0;
            abort_q   <= 1'b0;
            need_lo_q <= 1'b0;
            need_hi_q <= 1'b0;
            group_q   <= G_NONE;
            opcode_q  <= 8'h00;
            disp_q    <= 8'h00;
            imm_q     <= 16'h0000;
        end else begin
            run_q <= 1'b1;
            if (ocf_start || od_start)    out_q <= 1'b1;
            else if (ocf_take || od_take) out_q <= 1'b0;
            if (ocf_take || od_take)      abort_q <= 1'b0;
            else if (flush && out_q)      abort_q <= 1'b1;

            if (clr) begin
                need_lo_q <= 1'b0;
                need_hi_q <= 1'b0;
                group_q   <= G_NONE;
                opcode_q  <= 8'h00;
                disp_q    <= 8'h00;
                imm_q     <= 16'h0000;
            end else if (ocf_take) begin
                if (pfx_byte) begin
                    case (ocf_data)
                        8'hCB:   group_q <= is_idx ? ((group_q == G_DD) ? G_DDCB : G_FDCB) : G_CB;
                        8'hED:   group_q <= G_ED;
                        8'hDD:   group_q <= G_DD;
                        default: group_q <= G_FD;
                    endcase
                end else begin
                    opcode_q  <= ocf_data;
                    need_lo_q <= cls_nn || cls_n;
                    need_hi_q <= cls_nn;
                end
            end else if (od_take) begin
                case (state)
                    RD_DISP, XCB_DISP: disp_q         <= od_data;
                    RD_LO:             imm_q[7:0]     <= od_data;
                    RD_HI:             imm_q[15:8]    <= od_data;
                    XCB_OP:            opcode_q       <= od_data;
                    default: ;
                endcase
            end
        end
    end

    // A same-cycle flush withdraws the instruction so a concurrent ready is not an accept.
    assign instr_valid  = (state == PRESENT) && !flush;
    assign instr_group  = group_q;
    assign instr_opcode = opcode_q;
    assign instr_disp   = disp_q;
    assign instr_imm    = imm_q;
endmodule

// File: tb/tb_z80_opcode_sequencer.sv
// Bench for z80_opcode_sequencer: a byte-stream memory responder feeds fetches, a scoreboard
// of expected instructions is checked by an independent monitor at each accept.
module tb_z80_opcode_sequencer;
    logic        clk;
    logic        rst_L;
    logic        ocf_start, ocf_done, od_start, od_done;
    logic [7:0]  ocf_data, od_data;
    logic        flush, instr_valid, instr_ready;
    logic [2:0]  instr_group;
    logic [7:0]  instr_opcode, instr_disp;
    logic [15:0] instr_imm;

    z80_opcode_sequencer dut (
        .clk(clk), .rst_L(rst_L),
        .ocf_start(ocf_start), .ocf_done(ocf_done), .ocf_data(ocf_data),
        .od_start(od_start), .od_done(od_done), .od_data(od_data),
        .flush(flush), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_group(instr_group), .instr_opcode(instr_opcode),
        .instr_disp(instr_disp), .instr_imm(instr_imm)
    );

    typedef struct packed { logic kind; logic [7:0] dat; } byte_t;
    typedef struct packed { logic [2:0] grp; logic [7:0] op; logic [7:0] disp; logic [15:0] imm; } ins_t;

    byte_t bq[$];
    ins_t  eq[$];
    int n_checks = 0, n_fail = 0;
    int cyc = 0, done_cyc = 0, dangling = 0, rdy_mode = 2;
    logic prev_valid = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic add_byte(input logic kind, input logic [7:0] dat);
        byte_t b;
        b.kind = kind;
        b.dat  = dat;
        bq.push_back(b);
    endtask

    task automatic add_ins(input int grp, input logic [7:0] op, input logic [7:0] d, input logic [15:0] imm);
        ins_t e;
        e.grp  = 3'(grp);
        e.op   = op;
        e.disp = d;
        e.imm  = imm;
        eq.push_back(e);
    endtask

    // Operand needs from the Z80 x/y/z opcode fields; nd = displacement bytes, ni = immediate bytes.
    function automatic void classify(input int grp, input int b, output int nd, output int ni);
        int x, y, z;
        x = b / 64;
        y = (b / 8) % 8;
        z = b % 8;
        nd = 0;
        ni = 0;
        if (grp == 2) begin
            if (x == 1 && z == 3) ni = 2;
        end else if (grp == 0 || grp == 3 || grp == 4) begin
            if ((x == 0 && z == 1 && y % 2 == 0) || (x == 0 && z == 2 && y >= 4) ||
                (x == 3 && (z == 2 || z == 4)) || b == 'hC3 || b == 'hCD)
                ni = 2;
            else if (((x == 0 || x == 3) && z == 6) || b == 'hD3 || b == 'hDB ||
                     (x == 0 && z == 0 && y >= 2))
                ni = 1;
            if (grp != 0 && (b == 'h34 || b == 'h35 || b == 'h36 ||
                (x == 1 && (y == 6 || z == 6) && b != 'h76) || (x == 2 && z == 6)))
                nd = 1;
        end
    endfunction

    function automatic logic [7:0] rand_op();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255));
        while (b == 8'hCB || b == 8'hED || b == 8'hDD || b == 8'hFD);
        return b;
    endfunction

    task automatic gen_random();
        int form, k, nd, ni, grp;
        logic [7:0] op, d, lo, hi, p;
        form = $urandom_range(0, 5);
        grp = 0; d = 8'h00; lo = 8'h00; hi = 8'h00;
        if (form >= 3) begin
            k = $urandom_range(1, 3);
            for (int i = 0; i < k; i++) begin
                p = ($urandom_range(0, 1) == 1) ? 8'hDD : 8'hFD;
                add_byte(1'b1, p);
                grp = (p == 8'hDD) ? 3 : 4;
            end
        end
        if (form == 1) begin add_byte(1'b1, 8'hCB); grp = 1; end
        if (form == 2 || form == 5) begin add_byte(1'b1, 8'hED); grp = 2; end
        if (form == 4) begin
            add_byte(1'b1, 8'hCB);
            d  = 8'($urandom_range(0, 255));
            op = 8'($urandom_range(0, 255));
            add_byte(1'b0, d);
            add_byte(1'b0, op);
            add_ins(grp + 2, op, d, 16'h0000);
        end else begin
            op = rand_op();
            add_byte(1'b1, op);
            classify(grp, int'(op), nd, ni);
            if (nd == 1) begin d = 8'($urandom_range(0, 255)); add_byte(1'b0, d); end
            if (ni >= 1) begin lo = 8'($urandom_range(0, 255)); add_byte(1'b0, lo); end
            if (ni == 2) begin hi = 8'($urandom_range(0, 255)); add_byte(1'b0, hi); end
            add_ins(grp, op, d, {hi, lo});
        end
    endtask

    // Memory responder: serves fetches from the byte stream in order, with random latency.
    initial begin
        byte_t b;
        int lat;
        ocf_done = 1'b0; od_done = 1'b0; ocf_data = 8'h00; od_data = 8'h00;
        forever begin
            @(negedge clk);
            if (ocf_start || od_start) begin
                check("one_start", 64'(ocf_start && od_start), 64'(0));
                if (bq.size() == 0) begin
                    dangling++;
                end else begin
                    b = bq.pop_front();
                    check("start_kind", 64'(ocf_start), 64'(b.kind));
                    lat = $urandom_range(0, 2);
                    for (int i = 0; i < lat; i++) begin
                        @(negedge clk);
                        check("start_while_busy", 64'(ocf_start || od_start), 64'(0));
                    end
                    @(posedge clk); #1;
                    if (b.kind) begin ocf_done = 1'b1; ocf_data = b.dat; end
                    else        begin od_done  = 1'b1; od_data  = b.dat; end
                    done_cyc = cyc;
                    @(posedge clk); #1;
                    ocf_done = 1'b0;
                    od_done  = 1'b0;
                end
            end
        end
    end

    initial begin
        instr_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       instr_ready = ($urandom_range(0, 9) < 7);
                1:       instr_ready = 1'b0;
                default: instr_ready = 1'b1;
            endcase
        end
    end

    // Monitor: latency on each valid rise, scoreboard compare on each accept.
    initial forever begin
        ins_t e;
        @(negedge clk);
        if (instr_valid && !prev_valid)
            check("latency", 64'(cyc), 64'(done_cyc + 1));
        prev_valid = instr_valid;
        if (instr_valid && instr_ready) begin
            if (eq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL instr_unexpected: got %0h expected none", {instr_group, instr_opcode, instr_disp, instr_imm});
            end else begin
                e = eq.pop_front();
                check("instr", 64'({instr_group, instr_opcode, instr_disp, instr_imm}), 64'(e));
            end
        end
    end

    task automatic rst_assert(input bit chk);
        @(posedge clk); #2;
        rst_L = 1'b0;
        #1;
        if (chk)
            check("reset_outputs", 64'({ocf_start, od_start, instr_valid, instr_group,
                                        instr_opcode, instr_disp, instr_imm}), 64'(0));
        bq.delete();
        eq.delete();
        repeat (6) @(posedge clk);
    endtask

    task automatic rst_release();
        @(negedge clk);
        rst_L = 1'b1;
        #1;
        check("start_at_release", 64'(ocf_start), 64'(0));
        @(negedge clk);
        check("first_start", 64'(ocf_start), 64'(1));
    endtask

    task automatic wait_empty(input string name);
        int i;
        i = 0;
        while (eq.size() != 0 && i < 6000) begin
            @(negedge clk);
            i++;
        end
        check({name, "_drained"}, 64'(eq.size()), 64'(0));
        check({name, "_bytes_used"}, 64'(bq.size()), 64'(0));
    endtask

    task automatic wait_od_start(input string name);
        int i;
        i = 0;
        while (!od_start && i < 200) begin
            @(negedge clk);
            i++;
        end
        check({name, "_od_start_seen"}, 64'(od_start), 64'(1));
    endtask

    initial begin
        logic [37:0] snap;
        int i;
        rst_L = 1'b0;
        flush = 1'b0;

        rst_assert(1);
        add_byte(1, 8'h3E); add_byte(0, 8'h42);
        add_ins(0, 8'h3E, 8'h00, 16'h0042);
        rst_release();
        wait_empty("ld_a_n");

        rst_assert(1);
        rdy_mode = 1;
        add_byte(1, 8'hC3); add_byte(0, 8'h34); add_byte(0, 8'h12);
        add_ins(0, 8'hC3, 8'h00, 16'h1234);
        rst_release();
        i = 0;
        while (!instr_valid && i < 200) begin @(negedge clk); i++; end
        check("hold_valid_seen", 64'(instr_valid), 64'(1));
        snap = {instr_valid, instr_group, instr_opcode, instr_disp, instr_imm, ocf_start, od_start};
        repeat (5) begin
            @(negedge clk);
            check("hold_stable", 64'({instr_valid, instr_group, instr_opcode, instr_disp, instr_imm,
                                      ocf_start, od_start}), 64'(snap));
        end
        rdy_mode = 2;
        wait_empty("jp_nn");

        rst_assert(0);
        add_byte(1, 8'hDD); add_byte(1, 8'h36); add_byte(0, 8'h05); add_byte(0, 8'h99);
        add_ins(3, 8'h36, 8'h05, 16'h0099);
        rst_release();
        wait_empty("ld_ix_d_n");

        rst_assert(0);
        add_byte(1, 8'hFD); add_byte(1, 8'hCB); add_byte(0, 8'hFE); add_byte(0, 8'h46);
        add_ins(6, 8'h46, 8'hFE, 16'h0000);
        rst_release();
        wait_empty("bit_iy_d");

        rst_assert(0);
        add_byte(1, 8'hDD); add_byte(1, 8'hFD); add_byte(1, 8'hED); add_byte(1, 8'h4B);
        add_byte(0, 8'h00); add_byte(0, 8'h80);
        add_ins(2, 8'h4B, 8'h00, 16'h8000);
        rst_release();
        wait_empty("ed_ld_bc_nn");

        // Flush while the low operand byte is in flight: byte discarded, fetch restarts.
        rst_assert(0);
        add_byte(1, 8'h01); add_byte(0, 8'h55); add_byte(1, 8'h00);
        add_ins(0, 8'h00, 8'h00, 16'h0000);
        rst_release();
        wait_od_start("flush");
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        wait_empty("flush");

        // Reset in the middle of an instruction.
        rst_assert(0);
        add_byte(1, 8'h01); add_byte(0, 8'h34);
        rst_release();
        wait_od_start("midreset");
        rst_assert(1);
        add_byte(1, 8'h3E); add_byte(0, 8'h42);
        add_ins(0, 8'h3E, 8'h00, 16'h0042);
        rst_release();
        wait_empty("after_reset");

        rst_assert(0);
        rdy_mode = 0;
        for (int n = 0; n < 60; n++) gen_random();
        rst_release();
        wait_empty("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end
endmodule
